// File: rtl/morse_pkg.sv
// Shared types, unit lengths and the ASCII-to-Morse code table
// for the Morse transmit path.
package morse_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MARK,
      ELEM_GAP,
      LETTER_GAP,
      WORD_GAP
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] len;
      logic [4:0] pat;
   } morse_code_t;

   localparam int DOT_UNITS        = 1;
   localparam int DASH_UNITS       = 3;
   localparam int ELEM_GAP_UNITS   = 1;
   localparam int LETTER_GAP_UNITS = 3;
   localparam int WORD_EXTRA_UNITS = 4;

   function automatic logic [1:0] last_unit(input int units);
      return 2'(units - 1);
   endfunction

   function automatic morse_code_t mk(input logic [2:0] l,
                                      input logic [4:0] p);
      morse_code_t m;
      m.valid = 1'b1;
      m.len   = l;
      m.pat   = p;
      return m;
   endfunction

   // Patterns are left-aligned: bit 4 is the first element, 1 = dash.
   function automatic morse_code_t ascii_to_morse(input logic [7:0] ch);
      logic [7:0]  c;
      morse_code_t m;
      c = (ch >= 8'h61 && ch <= 8'h7a) ? ch - 8'h20 : ch;
      m = '0;
      case (c)
         8'h41: m = mk(3'd2, 5'b01000);
         8'h42: m = mk(3'd4, 5'b10000);
         8'h43: m = mk(3'd4, 5'b10100);
         8'h44: m = mk(3'd3, 5'b10000);
         8'h45: m = mk(3'd1, 5'b00000);
         8'h46: m = mk(3'd4, 5'b00100);
         8'h47: m = mk(3'd3, 5'b11000);
         8'h48: m = mk(3'd4, 5'b00000);
         8'h49: m = mk(3'd2, 5'b00000);
         8'h4a: m = mk(3'd4, 5'b01110);
         8'h4b: m = mk(3'd3, 5'b10100);
         8'h4c: m = mk(3'd4, 5'b01000);
         8'h4d: m = mk(3'd2, 5'b11000);
         8'h4e: m = mk(3'd2, 5'b10000);
         8'h4f: m = mk(3'd3, 5'b11100);
         8'h50: m = mk(3'd4, 5'b01100);
         8'h51: m = mk(3'd4, 5'b11010);
         8'h52: m = mk(3'd3, 5'b01000);
         8'h53: m = mk(3'd3, 5'b00000);
         8'h54: m = mk(3'd1, 5'b10000);
         8'h55: m = mk(3'd3, 5'b00100);
         8'h56: m = mk(3'd4, 5'b00010);
         8'h57: m = mk(3'd3, 5'b01100);
         8'h58: m = mk(3'd4, 5'b10010);
         8'h59: m = mk(3'd4, 5'b10110);
         8'h5a: m = mk(3'd4, 5'b11000);
         8'h30: m = mk(3'd5, 5'b11111);
         8'h31: m = mk(3'd5, 5'b01111);
         8'h32: m = mk(3'd5, 5'b00111);
         8'h33: m = mk(3'd5, 5'b00011);
         8'h34: m = mk(3'd5, 5'b00001);
         8'h35: m = mk(3'd5, 5'b00000);
         8'h36: m = mk(3'd5, 5'b10000);
         8'h37: m = mk(3'd5, 5'b11000);
         8'h38: m = mk(3'd5, 5'b11100);
         8'h39: m = mk(3'd5, 5'b11110);
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Free-running unit divider; restart realigns it so the first
// tick lands exactly UNIT_CYCLES cycles later.
module morse_unit_timer #(
   parameter int UNIT_CYCLES = 20_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic enable,
   output logic unit_tick
);

   localparam int W = $clog2(UNIT_CYCLES);
   localparam logic [W-1:0] LAST = W'(UNIT_CYCLES - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
      end
   end

   assign unit_tick = enable && (cnt == LAST);

endmodule

// File: rtl/morse_encoder.sv
// Morse transmitter: ASCII in over valid/ready, registered key out
// with standard dot/dash/gap unit timing.
module morse_encoder
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 20_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   output logic       key,
   output logic       busy,
   output logic       err
);

   state_t      state, state_nx;
   morse_code_t code;
   logic [4:0]  sreg;
   logic [2:0]  elems;
   logic [1:0]  ucnt, last;
   logic        tick, restart, hs, done, is_space;
   logic        key_nx, ready_nx, busy_nx, err_nx;

   assign code     = ascii_to_morse(char_in);
   assign is_space = (char_in == 8'h20);
   assign hs       = char_ready && char_valid;

   always_comb begin
      last = '0;
      unique case (state)
         MARK:       last = sreg[4] ? last_unit(DASH_UNITS)
                                    : last_unit(DOT_UNITS);
         ELEM_GAP:   last = last_unit(ELEM_GAP_UNITS);
         LETTER_GAP: last = last_unit(LETTER_GAP_UNITS);
         WORD_GAP:   last = last_unit(WORD_EXTRA_UNITS);
         default:    last = '0;
      endcase
   end

   assign done    = tick && (ucnt == last);
   assign restart = (state_nx != state);

   morse_unit_timer #(
      .UNIT_CYCLES(UNIT_CYCLES)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .restart  (restart),
      .enable   (state != IDLE),
      .unit_tick(tick)
   );

   // Outputs are computed from the next state and registered with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         key        <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
         char_ready <= 1'b1;
      end else begin
         state      <= state_nx;
         key        <= key_nx;
         busy       <= busy_nx;
         err        <= err_nx;
         char_ready <= ready_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (hs && is_space)        state_nx = WORD_GAP;
            else if (hs && code.valid) state_nx = MARK;
         end
         MARK: begin
            if (done) state_nx = (elems > 3'd1) ? ELEM_GAP : LETTER_GAP;
         end
         ELEM_GAP:   if (done) state_nx = MARK;
         LETTER_GAP: if (done) state_nx = IDLE;
         WORD_GAP:   if (done) state_nx = IDLE;
         default:    state_nx = IDLE;
      endcase
   end

   always_comb begin
      key_nx   = (state_nx == MARK);
      ready_nx = (state_nx == IDLE);
      busy_nx  = (state_nx != IDLE);
      err_nx   = (state == IDLE) && hs && !is_space && !code.valid;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sreg  <= '0;
         elems <= '0;
         ucnt  <= '0;
      end else begin
         if (restart)   ucnt <= '0;
         else if (tick) ucnt <= ucnt + 2'd1;
         if (state == IDLE && hs && code.valid) begin
            sreg  <= code.pat;
            elems <= code.len;
         end else if (state == ELEM_GAP && done) begin
            sreg  <= {sreg[3:0], 1'b0};
            elems <= elems - 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder with UNIT_CYCLES = 4.
module tb_morse_encoder;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] char_in;
   logic       char_valid;
   logic       char_ready, key, busy, err;

   int tests = 0;
   int fails = 0;

   logic tr[$];
   int   rl_len[$];
   logic rl_val[$];
   int   busy_n, err_n, rdy_cyc;

   always #5 clk = ~clk;

   morse_encoder #(.UNIT_CYCLES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .char_in   (char_in),
      .char_valid(char_valid),
      .char_ready(char_ready),
      .key       (key),
      .busy      (busy),
      .err       (err)
   );

   task automatic send(input logic [7:0] c);
      int n = 0;
      char_in    = c;
      char_valid = 1'b1;
      while (!char_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         tests++;
         fails++;
         $display("FAIL send_timeout char=%h ready=%b want 1", c, char_ready);
      end
      @(posedge clk);
      #1;
      char_valid = 1'b0;
   endtask

   // Samples from the cycle after the handshake until char_ready returns.
   task automatic capture(input int maxc);
      tr.delete();
      busy_n  = 0;
      err_n   = 0;
      rdy_cyc = -1;
      for (int i = 1; i <= maxc; i++) begin
         @(negedge clk);
         if (err) err_n++;
         if (char_ready) begin
            rdy_cyc = i;
            break;
         end
         tr.push_back(key);
         if (busy) busy_n++;
      end
   endtask

   function automatic string rl_str();
      string s = "";
      rl_len.delete();
      rl_val.delete();
      foreach (tr[i]) begin
         if (rl_len.size() == 0 || rl_val[rl_val.size()-1] != tr[i]) begin
            rl_len.push_back(1);
            rl_val.push_back(tr[i]);
         end else begin
            rl_len[rl_len.size()-1]++;
         end
      end
      foreach (rl_len[i])
         s = {s, $sformatf("%s%0d ", rl_val[i] ? "H" : "L", rl_len[i])};
      return s;
   endfunction

   task automatic test_reset();
      reset      = 1'b1;
      char_valid = 1'b0;
      char_in    = 8'h00;
      repeat (2) @(negedge clk);
      tests++;
      if ({key, busy, err, char_ready} !== 4'b0001) begin
         fails++;
         $display("FAIL reset_hold kbeR=%b want 0001",
                  {key, busy, err, char_ready});
      end
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if ({key, busy, err, char_ready} !== 4'b0001) begin
         fails++;
         $display("FAIL reset_release kbeR=%b want 0001",
                  {key, busy, err, char_ready});
      end
   endtask

   task automatic test_e();
      string s;
      send(8'h45);
      capture(100);
      s = rl_str();
      tests++;
      if (s != "H4 L12 ") begin
         fails++;
         $display("FAIL e_runs got '%s' want 'H4 L12 '", s);
      end
      tests++;
      if (rdy_cyc != 17) begin
         fails++;
         $display("FAIL e_ready got %0d want 17", rdy_cyc);
      end
      tests++;
      if (err_n != 0) begin
         fails++;
         $display("FAIL e_err got %0d want 0", err_n);
      end
   endtask

   task automatic test_a();
      string s;
      send(8'h41);
      capture(100);
      s = rl_str();
      tests++;
      if (s != "H4 L4 H12 L12 ") begin
         fails++;
         $display("FAIL a_runs got '%s' want 'H4 L4 H12 L12 '", s);
      end
      tests++;
      if (busy_n != 32) begin
         fails++;
         $display("FAIL a_busy got %0d want 32", busy_n);
      end
   endtask

   task automatic test_back_to_back();
      string s;
      char_in    = 8'h61;
      char_valid = 1'b1;
      @(posedge clk);
      #1;
      char_in = 8'h30;
      capture(100);
      s = rl_str();
      tests++;
      if (s != "H4 L4 H12 L12 ") begin
         fails++;
         $display("FAIL lc_a_runs got '%s' want 'H4 L4 H12 L12 '", s);
      end
      tests++;
      if (rdy_cyc != 33) begin
         fails++;
         $display("FAIL lc_a_ready got %0d want 33", rdy_cyc);
      end
      @(posedge clk);
      #1;
      char_valid = 1'b0;
      capture(200);
      s = rl_str();
      tests++;
      if (s != "H12 L4 H12 L4 H12 L4 H12 L4 H12 L12 ") begin
         fails++;
         $display("FAIL zero_runs got '%s' want 5 dashes", s);
      end
      tests++;
      if (busy_n != 88 || rdy_cyc != 89) begin
         fails++;
         $display("FAIL zero_len busy=%0d rdy=%0d want 88 89",
                  busy_n, rdy_cyc);
      end
   endtask

   task automatic test_word_gap();
      string s;
      int    sil = 0;
      send(8'h45);
      capture(100);
      for (int i = tr.size() - 1; i >= 0 && !tr[i]; i--) sil++;
      send(8'h20);
      capture(100);
      s = rl_str();
      tests++;
      if (s != "L16 " || busy_n != 16) begin
         fails++;
         $display("FAIL space_runs got '%s' busy=%0d want 'L16 ' 16",
                  s, busy_n);
      end
      sil += busy_n;
      send(8'h45);
      capture(100);
      for (int i = 0; i < tr.size() && !tr[i]; i++) sil++;
      tests++;
      if (sil != 28) begin
         fails++;
         $display("FAIL word_silence got %0d want 28", sil);
      end
   endtask

   task automatic test_unsupported();
      send(8'h23);
      capture(50);
      tests++;
      if (err_n != 1 || rdy_cyc != 1) begin
         fails++;
         $display("FAIL bad_char err=%0d rdy=%0d want 1 1", err_n, rdy_cyc);
      end
      @(negedge clk);
      tests++;
      if ({key, busy, err, char_ready} !== 4'b0001) begin
         fails++;
         $display("FAIL bad_char_after kbeR=%b want 0001",
                  {key, busy, err, char_ready});
      end
   endtask

   task automatic test_mid_reset();
      string s;
      send(8'h54);
      repeat (6) @(negedge clk);
      tests++;
      if (key !== 1'b1) begin
         fails++;
         $display("FAIL t_dash key=%b want 1", key);
      end
      #2;
      reset = 1'b1;
      #1;
      tests++;
      if ({key, busy, char_ready} !== 3'b001) begin
         fails++;
         $display("FAIL async_reset kbR=%b want 001",
                  {key, busy, char_ready});
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if ({key, busy, err, char_ready} !== 4'b0001) begin
         fails++;
         $display("FAIL post_reset kbeR=%b want 0001",
                  {key, busy, err, char_ready});
      end
      send(8'h45);
      capture(100);
      s = rl_str();
      tests++;
      if (s != "H4 L12 " || rdy_cyc != 17) begin
         fails++;
         $display("FAIL post_reset_e got '%s' rdy=%0d want 'H4 L12 ' 17",
                  s, rdy_cyc);
      end
   endtask

   initial begin
      test_reset();
      test_e();
      test_a();
      test_back_to_back();
      test_word_gap();
      test_unsupported();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
